sram_1r1w_lanes: RTL and testbench
==================================

Name: sram_1r1w_lanes

Overview:
- Parametrised single-clock 1-read/1-write SRAM model; successor to the fixed 16x256 dual-clock OpenRAM-style models.
- Adds configurable width/depth, per-lane write mask, registered read with valid strobe, and a post-reset clear sweep.
- Used as Leros register-file/data-memory backing store in simulation and FPGA builds.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
- ADDR_WIDTH, 8, address bits; RAM_DEPTH = 2**ADDR_WIDTH.
- LANE_WIDTH, 8, bits per write-mask lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- INIT_CLEAR, 1, 1 = zero all words after reset; 0 = no sweep, contents undefined.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the clear sweep runs; requests are ignored.
- w_csb  in  1  active-low write select.
- w_addr  in  ADDR_WIDTH  write address.
- w_wmask  in  NUM_LANES  per-lane write enable, bit i covers din[i*LANE_WIDTH +: LANE_WIDTH].
- w_din  in  DATA_WIDTH  write data.
- r_csb  in  1  active-low read select.
- r_addr  in  ADDR_WIDTH  read address.
- r_dout  out  DATA_WIDTH  read data, registered.
- r_valid  out  1  one-cycle strobe: r_dout updated at the last edge.

Behaviour:
- Reset (rst_n low, asynchronous): r_dout=0, r_valid=0, sweep counter=0. State = CLEAR if INIT_CLEAR=1, else RUN. init_busy=1 during reset; it drops at the first edge after release when INIT_CLEAR=0. Memory array itself is not reset.
- FSM states: CLEAR, RUN.
- CLEAR: each posedge writes 0 to mem[cnt] and increments cnt. After writing RAM_DEPTH-1 go to RUN, so the sweep takes exactly RAM_DEPTH cycles. init_busy=1 throughout.
- During CLEAR, w_csb and r_csb are ignored: no writes, r_valid stays 0, r_dout holds 0.
- RUN write: at a posedge with w_csb=0, each lane with w_wmask[i]=1 is updated from w_din; other lanes keep their old value. A write with an all-zero mask is a no-op.
- RUN read: at a posedge with r_csb=0, r_dout <= mem[r_addr] and r_valid <= 1 (latency 1 edge). If r_csb=1, r_valid <= 0 and r_dout holds its previous value.
- Back-to-back reads: one result per cycle; r_valid stays high continuously.
- Collision (both selected, same address, same edge): resolved per Optional Feature. Different addresses are fully independent.
- Reset asserted mid-sweep or mid-run: immediate return to reset values; the sweep restarts from address 0.
- Out-of-range addresses are impossible (depth = 2**ADDR_WIDTH); the counter wraps naturally and is never used past RAM_DEPTH-1.
- Elaboration check: DATA_WIDTH % LANE_WIDTH != 0 raises $error.

Optional Feature:
- Macro SRAM_1R1W_BYPASS_EN.
- Defined: on a collision, r_dout takes w_din on masked lanes and old memory data on unmasked lanes (write-first).
- Undefined: on a collision, r_dout returns the old word in full (read-first). The write still completes in both cases.

Decomposition:
- Shared package sram_pkg holds lane-count function, the clear-FSM state enum (SRAM_CLEAR, SRAM_RUN), and the lane-merge function merge(old, new, mask). The merge function is used by both the write path and the bypass path.
- One natural sub-module: sram_clear_seq (counter + FSM, outputs init_busy, clr_we, clr_addr). The array and ports stay in the top module.

Test Plan:
- Defaults, INIT_CLEAR=1: release reset -> init_busy high exactly 256 cycles; then reads of addr 0x00, 0x7F, 0xFF return 0x0000 with r_valid pulsing.
- Write 0xA5C3 to addr 0x10 with mask 2'b11, then mask 2'b01 with 0xFF11, then read 0x10 -> 0xA511; mask 2'b00 write leaves 0xA511.
- Collision: mem[0x20]=0x1234; same edge write 0xBEEF mask 2'b10 and read 0x20 -> 0xBE34 with BYPASS_EN, 0x1234 without; a following read returns 0xBE34 in both builds.
- Reads to 0x01, 0x02, 0x03 on consecutive edges -> r_valid high 3 cycles, data in order. Then r_csb=1 -> r_valid 0 and r_dout holds the 0x03 data.
- rst_n pulsed low at sweep cycle 100 -> outputs zero immediately; a fresh 256-cycle sweep follows; a write issued during the sweep is lost (read afterwards = 0).
- INIT_CLEAR=0, DATA_WIDTH=32, LANE_WIDTH=8, ADDR_WIDTH=4 -> init_busy drops after the first edge; a 4-lane masked write/read-back of 0xDEADBEEF with mask 4'b0101 checks the lane merge on written data.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W lane-masked SRAM: clear-FSM states,
// lane count and the lane-merge function used by both the write and bypass paths.
package sram_pkg;

  // Upper bounds for the width-generic merge helper; callers cast to/from these.
  localparam int SRAM_MAX_W     = 256;
  localparam int SRAM_MAX_LANES = 256;

  typedef enum logic {
    SRAM_CLEAR = 1'b0,
    SRAM_RUN   = 1'b1
  } sram_state_e;

  function automatic int lane_count(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Lanes whose mask bit is set take new_w, the rest keep old_w.
  function automatic logic [SRAM_MAX_W-1:0] merge(
    input logic [SRAM_MAX_W-1:0]     old_w,
    input logic [SRAM_MAX_W-1:0]     new_w,
    input logic [SRAM_MAX_LANES-1:0] mask,
    input int                        lane_w
  );
    logic [SRAM_MAX_W-1:0] res;
    int lane;
    res = old_w;
    for (int i = 0; i < SRAM_MAX_W; i++) begin
      lane = i / lane_w;
      if (mask[lane[7:0]]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sweep: walks every address once writing zero, then parks in RUN.
// init_busy is registered and stays high for the whole sweep (or one edge when INIT_CLEAR=0).
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output sram_state_e           clr_state
);

  localparam sram_state_e RESET_STATE = INIT_CLEAR ? SRAM_CLEAR : SRAM_RUN;

  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state <= RESET_STATE;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (clr_state)
        SRAM_CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          // The edge that clears the last word also ends the sweep.
          if (cnt == '1) begin
            clr_state <= SRAM_RUN;
            init_busy <= 1'b0;
          end
        end
        SRAM_RUN: begin
          init_busy <= 1'b0;
        end
        default: begin
          clr_state <= RESET_STATE;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (clr_state == SRAM_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/sram_1r1w_lanes.sv
// Parametrised single-clock 1R1W SRAM with per-lane write mask, registered read + valid
// strobe and optional post-reset clear. Define SRAM_1R1W_BYPASS_EN for write-first collisions.
module sram_1r1w_lanes
  import sram_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 8,
  parameter  int LANE_WIDTH = 8,
  parameter  int INIT_CLEAR = 1,
  localparam int NUM_LANES  = lane_count(DATA_WIDTH, LANE_WIDTH),
  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  w_csb,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [NUM_LANES-1:0]  w_wmask,
  input  logic [DATA_WIDTH-1:0] w_din,
  input  logic                  r_csb,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_dout,
  output logic                  r_valid
);

  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane
    $error("sram_1r1w_lanes: DATA_WIDTH (%0d) is not a multiple of LANE_WIDTH (%0d)",
           DATA_WIDTH, LANE_WIDTH);
  end
  if (DATA_WIDTH > SRAM_MAX_W) begin : g_too_wide
    $error("sram_1r1w_lanes: DATA_WIDTH (%0d) exceeds SRAM_MAX_W", DATA_WIDTH);
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  sram_state_e           clr_state;

  sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_CLEAR (INIT_CLEAR != 0)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_state (clr_state)
  );

  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef SRAM_1R1W_BYPASS_EN
  logic collide;
  assign collide = !w_csb && !r_csb && (w_addr == r_addr);
`endif

  always_comb begin
    wr_word = DATA_WIDTH'(merge(SRAM_MAX_W'(mem[w_addr]), SRAM_MAX_W'(w_din),
                                SRAM_MAX_LANES'(w_wmask), LANE_WIDTH));
`ifdef SRAM_1R1W_BYPASS_EN
    // Same-address write this edge: forward the merged word (write-first).
    rd_word = collide ? wr_word : mem[r_addr];
`else
    rd_word = mem[r_addr];
`endif
  end

  // The array itself is never reset; the clear sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (!init_busy && !w_csb && (|w_wmask)) begin
      mem[w_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (init_busy) begin
      r_valid <= 1'b0;
    end else if (!r_csb) begin
      r_dout  <= rd_word;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  a_clear_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (clr_state == SRAM_CLEAR) |-> (init_busy && clr_we));

endmodule

// File: tb/tb_sram_1r1w_lanes.sv
// Bench for sram_1r1w_lanes: default 16x256 instance checked every cycle against a
// lane-level memory model, plus a 32x16 no-clear instance for the 4-lane merge case.
module tb_sram_1r1w_lanes;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;

  // ---------------- DUT 0: defaults ----------------
  logic        init_busy;
  logic        w_csb = 1'b1;
  logic [7:0]  w_addr = '0;
  logic [1:0]  w_wmask = '0;
  logic [15:0] w_din = '0;
  logic        r_csb = 1'b1;
  logic [7:0]  r_addr = '0;
  logic [15:0] r_dout;
  logic        r_valid;

  sram_1r1w_lanes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .w_csb     (w_csb),
    .w_addr    (w_addr),
    .w_wmask   (w_wmask),
    .w_din     (w_din),
    .r_csb     (r_csb),
    .r_addr    (r_addr),
    .r_dout    (r_dout),
    .r_valid   (r_valid)
  );

  // ---------------- DUT 1: 32-bit, 16 deep, no sweep ----------------
  logic        busy1;
  logic        w1_csb = 1'b1;
  logic [3:0]  w1_addr = '0;
  logic [3:0]  w1_wmask = '0;
  logic [31:0] w1_din = '0;
  logic        r1_csb = 1'b1;
  logic [3:0]  r1_addr = '0;
  logic [31:0] r1_dout;
  logic        r1_valid;

  sram_1r1w_lanes #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .LANE_WIDTH (8),
    .INIT_CLEAR (0)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .init_busy (busy1),
    .w_csb     (w1_csb),
    .w_addr    (w1_addr),
    .w_wmask   (w1_wmask),
    .w_din     (w1_din),
    .r_csb     (r1_csb),
    .r_addr    (r1_addr),
    .r_dout    (r1_dout),
    .r_valid   (r1_valid)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of DUT 0 ----------------
  // Memory of words, a countdown of remaining sweep edges, and the read register.
  logic [15:0] m_mem [256];
  int          m_busy_left = 256;
  logic        m_busy  = 1'b1;
  logic        m_valid = 1'b0;
  logic [15:0] m_dout  = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] rd;
    if (!rst_n) begin
      m_busy_left = 256;
      m_busy      = 1'b1;
      m_valid     = 1'b0;
      m_dout      = '0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      m_valid = 1'b0;
      if (m_busy_left == 0) begin
        for (int a = 0; a < 256; a++) m_mem[a] = '0;
        m_busy = 1'b0;
      end
    end else begin
      if (!r_csb) begin
        rd = m_mem[r_addr];
`ifdef SRAM_1R1W_BYPASS_EN
        if (!w_csb && (w_addr == r_addr))
          for (int l = 0; l < 2; l++)
            if (w_wmask[l]) rd[l*8 +: 8] = w_din[l*8 +: 8];
`endif
        m_dout  = rd;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (!w_csb)
        for (int l = 0; l < 2; l++)
          if (w_wmask[l]) m_mem[w_addr][l*8 +: 8] = w_din[l*8 +: 8];
    end
  end

  // Single compare process: every falling edge, outputs vs model.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy",  {31'd0, init_busy}, {31'd0, m_busy});
      check("model_valid", {31'd0, r_valid},   {31'd0, m_valid});
      check("model_dout",  {16'd0, r_dout},    {16'd0, m_dout});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic we, input logic [7:0] wa, input logic [1:0] wm,
                    input logic [15:0] wd, input logic re, input logic [7:0] ra);
    @(negedge clk);
    w_csb = !we; w_addr = wa; w_wmask = wm; w_din = wd;
    r_csb = !re; r_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    w_csb = 1'b1; r_csb = 1'b1;
  endtask

  task automatic op1(input logic we, input logic [3:0] wa, input logic [3:0] wm,
                     input logic [31:0] wd, input logic re, input logic [3:0] ra);
    @(negedge clk);
    w1_csb = !we; w1_addr = wa; w1_wmask = wm; w1_din = wd;
    r1_csb = !re; r1_addr = ra;
    @(posedge clk);
    #1;
  endtask

  // Counts posedges until init_busy drops; returns 400 on timeout.
  task automatic wait_sweep(output int n);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (!init_busy) break;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [15:0] coll_exp;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1;
    check("reset_busy",  {31'd0, init_busy}, 32'd1);
    check("reset_valid", {31'd0, r_valid},   32'd0);
    check("reset_dout",  {16'd0, r_dout},    32'd0);
    check("reset_busy1", {31'd0, busy1},     32'd1);

    // No-clear 32-bit instance: busy drops after one edge, 4-lane merge.
    @(negedge clk); #2 rst1_n = 1'b1;
    @(posedge clk); #1;
    check("busy1_drop", {31'd0, busy1}, 32'd0);
    op1(1'b1, 4'd3, 4'b1111, 32'h1122_3344, 1'b0, 4'd0);
    op1(1'b1, 4'd3, 4'b0101, 32'hDEAD_BEEF, 1'b0, 4'd0);
    op1(1'b0, 4'd0, 4'b0000, 32'h0,         1'b1, 4'd3);
    check("lane4_valid", {31'd0, r1_valid}, 32'd1);
    check("lane4_data",  r1_dout,          32'h11AD_33EF);
    @(negedge clk); w1_csb = 1'b1; r1_csb = 1'b1;

    // Default instance: 256-edge clear sweep.
    @(negedge clk); #2 rst_n = 1'b1;
    wait_sweep(n);
    check("sweep_len", n, 32'd256);

    op(1'b0, 8'h00, 2'b00, 16'h0, 1'b1, 8'h00);
    check("clr_rd00_v", {31'd0, r_valid}, 32'd1);
    check("clr_rd00",   {16'd0, r_dout},  32'h0);
    op(1'b0, 8'h00, 2'b00, 16'h0, 1'b1, 8'h7F);
    check("clr_rd7f",   {16'd0, r_dout},  32'h0);
    op(1'b0, 8'h00, 2'b00, 16'h0, 1'b1, 8'hFF);
    check("clr_rdff",   {16'd0, r_dout},  32'h0);
    idle();

    // Lane-masked writes.
    op(1'b1, 8'h10, 2'b11, 16'hA5C3, 1'b0, 8'h00);
    op(1'b1, 8'h10, 2'b01, 16'hFF11, 1'b0, 8'h00);
    op(1'b0, 8'h00, 2'b00, 16'h0,    1'b1, 8'h10);
    check("mask_merge", {16'd0, r_dout}, 32'hA511);
    op(1'b1, 8'h10, 2'b00, 16'h0000, 1'b0, 8'h00);
    op(1'b0, 8'h00, 2'b00, 16'h0,    1'b1, 8'h10);
    check("mask_none",  {16'd0, r_dout}, 32'hA511);
    idle();

    // Same-address collision.
`ifdef SRAM_1R1W_BYPASS_EN
    coll_exp = 16'hBE34;
`else
    coll_exp = 16'h1234;
`endif
    op(1'b1, 8'h20, 2'b11, 16'h1234, 1'b0, 8'h00);
    op(1'b1, 8'h20, 2'b10, 16'hBEEF, 1'b1, 8'h20);
    check("collide_rd", {16'd0, r_dout}, {16'd0, coll_exp});
    op(1'b0, 8'h00, 2'b00, 16'h0,    1'b1, 8'h20);
    check("collide_after", {16'd0, r_dout}, 32'hBE34);
    idle();

    // Back-to-back reads then a hold cycle.
    op(1'b1, 8'h01, 2'b11, 16'h0101, 1'b0, 8'h00);
    op(1'b1, 8'h02, 2'b11, 16'h0202, 1'b0, 8'h00);
    op(1'b1, 8'h03, 2'b11, 16'h0303, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      op(1'b0, 8'h00, 2'b00, 16'h0, 1'b1, 8'(i));
      check("b2b_valid", {31'd0, r_valid}, 32'd1);
      check("b2b_data",  {16'd0, r_dout},  {16'd0, 8'(i), 8'(i)});
    end
    idle();
    @(posedge clk); #1;
    check("hold_valid", {31'd0, r_valid}, 32'd0);
    check("hold_dout",  {16'd0, r_dout},  32'h0303);

    // Randomized traffic; narrow address window half the time to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      w_csb   = 1'($urandom_range(0, 1));
      r_csb   = 1'($urandom_range(0, 1));
      w_wmask = 2'($urandom_range(0, 3));
      w_din   = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        w_addr = 8'($urandom_range(0, 7));
        r_addr = 8'($urandom_range(0, 7));
      end else begin
        w_addr = 8'($urandom_range(0, 255));
        r_addr = ($urandom_range(0, 3) == 0) ? w_addr : 8'($urandom_range(0, 255));
      end
    end
    idle();

    // Reset mid-run with non-zero read data.
    op(1'b1, 8'h03, 2'b11, 16'h5A5A, 1'b0, 8'h00);
    op(1'b0, 8'h00, 2'b00, 16'h0,    1'b1, 8'h03);
    check("pre_rst_dout", {16'd0, r_dout}, 32'h5A5A);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("run_rst_dout",  {16'd0, r_dout},  32'h0);
    check("run_rst_valid", {31'd0, r_valid}, 32'd0);
    check("run_rst_busy",  {31'd0, init_busy}, 32'd1);

    // Reset again at sweep edge 100.
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("sweep_rst_busy",  {31'd0, init_busy}, 32'd1);
    check("sweep_rst_dout",  {16'd0, r_dout},    32'h0);

    // Fresh sweep with a write attempted on its first edge.
    @(negedge clk); #2 rst_n = 1'b1;
    w_csb = 1'b0; w_addr = 8'h10; w_wmask = 2'b11; w_din = 16'hFFFF;
    r_csb = 1'b0; r_addr = 8'h10;
    @(posedge clk); #1;
    w_csb = 1'b1; r_csb = 1'b1;
    check("sweep_rd_ignored", {31'd0, r_valid}, 32'd0);
    wait_sweep(n);
    check("resweep_len", n + 1, 32'd256);
    op(1'b0, 8'h00, 2'b00, 16'h0, 1'b1, 8'h10);
    check("lost_write_v", {31'd0, r_valid}, 32'd1);
    check("lost_write",   {16'd0, r_dout},  32'h0);
    idle();
    repeat (2) @(posedge clk);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
